// File: rtl/cpu_pkg.sv
// Shared CPU constants: opcodes, sequencer states, bus mux selects.
// Reused by the control unit, alu_block and the datapath.
package cpu_pkg;

  localparam int word_size = 8;

  typedef logic [3:0] opcode_t;

  localparam opcode_t NOP = 4'd0;
  localparam opcode_t ADD = 4'd1;
  localparam opcode_t SUB = 4'd2;
  localparam opcode_t AND = 4'd3;
  localparam opcode_t NOT = 4'd4;
  localparam opcode_t RD  = 4'd5;
  localparam opcode_t WR  = 4'd6;
  localparam opcode_t BR  = 4'd7;
  localparam opcode_t BRZ = 4'd8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FET1,
    S_FET2,
    S_DEC,
    S_EX1,
    S_RD1,
    S_RD2,
    S_WR1,
    S_WR2,
    S_BR1,
    S_BR2,
    S_HALT
  } state_t;

  localparam logic [2:0] SEL1_R0 = 3'd0;
  localparam logic [2:0] SEL1_R1 = 3'd1;
  localparam logic [2:0] SEL1_R2 = 3'd2;
  localparam logic [2:0] SEL1_R3 = 3'd3;
  localparam logic [2:0] SEL1_PC = 3'd4;

  localparam logic [1:0] SEL2_ALU  = 2'd0;
  localparam logic [1:0] SEL2_BUS1 = 2'd1;
  localparam logic [1:0] SEL2_MEM  = 2'd2;

  typedef struct packed {
    opcode_t    opcode;
    logic [1:0] src;
    logic [1:0] dest;
    logic [3:0] load_dest;
  } ir_fields_t;

  typedef struct packed {
    logic [3:0] load_r;
    logic       load_pc;
    logic       inc_pc;
    logic       load_ir;
    logic       load_add_r;
    logic       load_reg_y;
    logic       load_reg_z;
    logic       write;
    logic [2:0] sel_bus_1;
    logic [1:0] sel_bus_2;
    opcode_t    alu_sel;
    logic       halted;
    logic       instr_done;
  } ctrl_t;

  function automatic logic [2:0] reg_sel(logic [1:0] r);
    return {1'b0, r};
  endfunction

endpackage

// File: rtl/cpu_control_unit_if.sv
// Control bundle between the sequencer (master) and datapath (slave).
// IR contents and Reg_Z flow in; every strobe and select flows out.
interface cpu_control_unit_if;
  import cpu_pkg::*;

  logic [word_size-1:0] instruction;
  logic                 zero;
  logic                 load_R0;
  logic                 load_R1;
  logic                 load_R2;
  logic                 load_R3;
  logic                 load_PC;
  logic                 inc_PC;
  logic                 load_IR;
  logic                 load_Add_R;
  logic                 load_Reg_Y;
  logic                 load_Reg_Z;
  logic                 write;
  logic [2:0]           sel_bus_1_mux;
  logic [1:0]           sel_bus_2_mux;
  logic [3:0]           alu_sel;
  logic                 halted;
  logic                 instr_done;

  modport master (
    input  instruction, zero,
    output load_R0, load_R1, load_R2, load_R3,
    output load_PC, inc_PC, load_IR, load_Add_R,
    output load_Reg_Y, load_Reg_Z, write,
    output sel_bus_1_mux, sel_bus_2_mux, alu_sel,
    output halted, instr_done
  );

  modport slave (
    output instruction, zero,
    input  load_R0, load_R1, load_R2, load_R3,
    input  load_PC, inc_PC, load_IR, load_Add_R,
    input  load_Reg_Y, load_Reg_Z, write,
    input  sel_bus_1_mux, sel_bus_2_mux, alu_sel,
    input  halted, instr_done
  );

endinterface

// File: rtl/cpu_control_unit_decode.sv
// Splits the IR into opcode / src / dest and a one-hot dest load.
// Purely combinational.
module instr_field_decode
  import cpu_pkg::*;
(
  input  logic [word_size-1:0] instruction,
  output ir_fields_t           fields
);

  always_comb begin
    fields.opcode    = instruction[7:4];
    fields.src       = instruction[3:2];
    fields.dest      = instruction[1:0];
    fields.load_dest = 4'b0001 << instruction[1:0];
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle Moore sequencer for the 8-bit CPU datapath.
// Outputs decode from state, IR fields and Reg_Z only.
module cpu_control_unit
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  cpu_control_unit_if.master  bus
);

  state_t     state;
  state_t     state_nxt;
  ir_fields_t f;
  ctrl_t      c;

  instr_field_decode u_dec (
    .instruction (bus.instruction),
    .fields      (f)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: state_nxt = S_FET1;
      S_FET1: state_nxt = S_FET2;
      S_FET2: state_nxt = S_DEC;
      S_DEC: begin
        unique case (1'b1)
          (f.opcode == NOP): state_nxt = S_FET1;
          (f.opcode == ADD),
          (f.opcode == SUB),
          (f.opcode == AND): state_nxt = S_EX1;
          (f.opcode == NOT): state_nxt = S_FET1;
          (f.opcode == RD):  state_nxt = S_RD1;
          (f.opcode == WR):  state_nxt = S_WR1;
          (f.opcode == BR):  state_nxt = S_BR1;
          (f.opcode == BRZ):
            state_nxt = bus.zero ? S_BR1 : S_FET1;
          default:           state_nxt = S_HALT;
        endcase
      end
      S_EX1:  state_nxt = S_FET1;
      S_RD1:  state_nxt = S_RD2;
      S_RD2:  state_nxt = S_FET1;
      S_WR1:  state_nxt = S_WR2;
      S_WR2:  state_nxt = S_FET1;
      S_BR1:  state_nxt = S_BR2;
      S_BR2:  state_nxt = S_FET1;
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    c = '0;
    unique case (state)
      S_FET1: begin
        c.sel_bus_1  = SEL1_PC;
        c.sel_bus_2  = SEL2_BUS1;
        c.load_add_r = 1'b1;
      end
      S_FET2: begin
        c.sel_bus_2 = SEL2_MEM;
        c.load_ir   = 1'b1;
        c.inc_pc    = 1'b1;
      end
      S_DEC: begin
        unique case (1'b1)
          (f.opcode == NOP): c.instr_done = 1'b1;
          (f.opcode == ADD),
          (f.opcode == SUB),
          (f.opcode == AND): begin
            c.sel_bus_1  = reg_sel(f.src);
            c.load_reg_y = 1'b1;
          end
          (f.opcode == NOT): begin
            c.sel_bus_1  = reg_sel(f.src);
            c.sel_bus_2  = SEL2_ALU;
            c.alu_sel    = NOT;
            c.load_reg_z = 1'b1;
            c.load_r     = f.load_dest;
            c.instr_done = 1'b1;
          end
          (f.opcode == RD),
          (f.opcode == WR),
          (f.opcode == BR): begin
            c.sel_bus_1  = SEL1_PC;
            c.sel_bus_2  = SEL2_BUS1;
            c.load_add_r = 1'b1;
          end
          (f.opcode == BRZ): begin
            if (bus.zero) begin
              c.sel_bus_1  = SEL1_PC;
              c.sel_bus_2  = SEL2_BUS1;
              c.load_add_r = 1'b1;
            end else begin
              // untaken: step PC past the target word
              c.inc_pc     = 1'b1;
              c.instr_done = 1'b1;
            end
          end
          default: ;
        endcase
      end
      S_EX1: begin
        c.sel_bus_1  = reg_sel(f.dest);
        c.sel_bus_2  = SEL2_ALU;
        c.alu_sel    = f.opcode;
        c.load_reg_z = 1'b1;
        c.load_r     = f.load_dest;
        c.instr_done = 1'b1;
      end
      S_RD1, S_WR1: begin
        c.sel_bus_2  = SEL2_MEM;
        c.load_add_r = 1'b1;
        c.inc_pc     = 1'b1;
      end
      S_RD2: begin
        c.sel_bus_2  = SEL2_MEM;
        c.load_r     = f.load_dest;
        c.instr_done = 1'b1;
      end
      S_WR2: begin
        c.sel_bus_1  = reg_sel(f.src);
        c.write      = 1'b1;
        c.instr_done = 1'b1;
      end
      S_BR1: begin
        c.sel_bus_2  = SEL2_MEM;
        c.load_add_r = 1'b1;
      end
      S_BR2: begin
        c.sel_bus_2  = SEL2_MEM;
        c.load_pc    = 1'b1;
        c.instr_done = 1'b1;
      end
      S_HALT: c.halted = 1'b1;
      default: ;
    endcase
  end

  assign bus.load_R0       = c.load_r[0];
  assign bus.load_R1       = c.load_r[1];
  assign bus.load_R2       = c.load_r[2];
  assign bus.load_R3       = c.load_r[3];
  assign bus.load_PC       = c.load_pc;
  assign bus.inc_PC        = c.inc_pc;
  assign bus.load_IR       = c.load_ir;
  assign bus.load_Add_R    = c.load_add_r;
  assign bus.load_Reg_Y    = c.load_reg_y;
  assign bus.load_Reg_Z    = c.load_reg_z;
  assign bus.write         = c.write;
  assign bus.sel_bus_1_mux = c.sel_bus_1;
  assign bus.sel_bus_2_mux = c.sel_bus_2;
  assign bus.alu_sel       = c.alu_sel;
  assign bus.halted        = c.halted;
  assign bus.instr_done    = c.instr_done;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: directed table, random program
// against a per-instruction cycle model, halt and reset cases.
module tb_cpu_control_unit;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  cpu_control_unit_if bus ();

  cpu_control_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0] ld;
    logic       pc;
    logic       inc;
    logic       ir;
    logic       add;
    logic       y;
    logic       z;
    logic       wr;
    logic [2:0] s1;
    logic [1:0] s2;
    logic [3:0] alu;
    logic       hlt;
    logic       done;
  } o_t;

  typedef struct {
    logic [7:0] ir;
    logic       z;
    int         cpi;
    int         incs;
    int         wrs;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic o_t sample();
    o_t o;
    o.ld   = {bus.load_R3, bus.load_R2,
              bus.load_R1, bus.load_R0};
    o.pc   = bus.load_PC;
    o.inc  = bus.inc_PC;
    o.ir   = bus.load_IR;
    o.add  = bus.load_Add_R;
    o.y    = bus.load_Reg_Y;
    o.z    = bus.load_Reg_Z;
    o.wr   = bus.write;
    o.s1   = bus.sel_bus_1_mux;
    o.s2   = bus.sel_bus_2_mux;
    o.alu  = bus.alu_sel;
    o.hlt  = bus.halted;
    o.done = bus.instr_done;
    return o;
  endfunction

  task automatic check(input string name, input o_t exp);
    o_t act;
    act = sample();
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name,
                           input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected outputs in cycle k (0 = FET1) of instruction ir.
  function automatic o_t model(logic [7:0] ir, logic z, int k);
    o_t o;
    int op;
    int s;
    int d;
    o  = '0;
    op = int'(ir[7:4]);
    s  = int'(ir[3:2]);
    d  = int'(ir[1:0]);
    if (k == 0) begin
      o.s1 = 3'd4; o.s2 = 2'd1; o.add = 1'b1;
    end else if (k == 1) begin
      o.s2 = 2'd2; o.ir = 1'b1; o.inc = 1'b1;
    end else if (k == 2) begin
      if (op == 0) o.done = 1'b1;
      else if (op >= 1 && op <= 3) begin
        o.s1 = 3'(s); o.y = 1'b1;
      end else if (op == 4) begin
        o.s1 = 3'(s); o.s2 = 2'd0; o.alu = 4'd4;
        o.z = 1'b1; o.ld[d] = 1'b1; o.done = 1'b1;
      end else if ((op >= 5 && op <= 7) || (op == 8 && z)) begin
        o.s1 = 3'd4; o.s2 = 2'd1; o.add = 1'b1;
      end else if (op == 8) begin
        o.inc = 1'b1; o.done = 1'b1;
      end
    end else if (k == 3) begin
      if (op >= 1 && op <= 3) begin
        o.s1 = 3'(d); o.s2 = 2'd0; o.alu = 4'(op);
        o.z = 1'b1; o.ld[d] = 1'b1; o.done = 1'b1;
      end else if (op == 5 || op == 6) begin
        o.s2 = 2'd2; o.add = 1'b1; o.inc = 1'b1;
      end else begin
        o.s2 = 2'd2; o.add = 1'b1;
      end
    end else begin
      if (op == 5) begin
        o.s2 = 2'd2; o.ld[d] = 1'b1; o.done = 1'b1;
      end else if (op == 6) begin
        o.s1 = 3'(s); o.wr = 1'b1; o.done = 1'b1;
      end else begin
        o.s2 = 2'd2; o.pc = 1'b1; o.done = 1'b1;
      end
    end
    return o;
  endfunction

  function automatic int cpi_of(logic [7:0] ir, logic z);
    int op;
    op = int'(ir[7:4]);
    if (op == 0 || op == 4) return 3;
    if (op >= 1 && op <= 3) return 4;
    if (op == 8) return z ? 5 : 3;
    if (op >= 5 && op <= 7) return 5;
    return 3;
  endfunction

  // Entered on a negedge with the DUT in FET1. zero is only
  // held to z in DEC; elsewhere it toggles randomly.
  task automatic run_instr(input logic [7:0] ir, input logic z,
                           input int ncyc, input bit adv_last,
                           output int incs, output int wrs);
    logic r;
    incs = 0;
    wrs  = 0;
    for (int k = 0; k < ncyc; k++) begin
      if (k == 0) bus.instruction = ir;
      r = 1'($urandom);
      bus.zero = (k == 2) ? z : r;
      #1;
      check($sformatf("ir%02h_z%0d_c%0d", ir, z, k),
            model(ir, z, k));
      if (bus.inc_PC) incs++;
      if (bus.write) wrs++;
      if (k < ncyc - 1 || adv_last) begin
        @(posedge clk);
        @(negedge clk);
      end
    end
  endtask

  vec_t vecs[$];
  int   incs;
  int   wrs;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    logic [7:0]  ir;
    logic        z;

    vecs.push_back('{8'h00, 1'b0, 3, 1, 0});
    vecs.push_back('{8'h16, 1'b0, 4, 1, 0});
    vecs.push_back('{8'h53, 1'b0, 5, 2, 0});
    vecs.push_back('{8'h64, 1'b0, 5, 2, 1});
    vecs.push_back('{8'h80, 1'b0, 3, 2, 0});
    vecs.push_back('{8'h80, 1'b1, 5, 1, 0});
    vecs.push_back('{8'h4B, 1'b0, 3, 1, 0});
    vecs.push_back('{8'h2D, 1'b1, 4, 1, 0});
    vecs.push_back('{8'h3E, 1'b0, 4, 1, 0});
    vecs.push_back('{8'h70, 1'b0, 5, 1, 0});
    vecs.push_back('{8'h59, 1'b1, 5, 2, 0});

    rst_n = 1'b0;
    bus.instruction = 8'h00;
    bus.zero = 1'b0;
    #3;
    check("reset_async", '0);
    @(negedge clk);
    check("reset_held", '0);
    rst_n = 1'b1;
    #1;
    check("idle", '0);
    @(posedge clk);
    @(negedge clk);

    foreach (vecs[i]) begin
      run_instr(vecs[i].ir, vecs[i].z, vecs[i].cpi, 1'b1,
                incs, wrs);
      check_int($sformatf("inc_cnt_%02h", vecs[i].ir),
                incs, vecs[i].incs);
      check_int($sformatf("wr_cnt_%02h", vecs[i].ir),
                wrs, vecs[i].wrs);
    end

    for (int n = 0; n < 200; n++) begin
      r  = $urandom;
      ir = {4'($urandom_range(0, 8)), r[3:0]};
      z  = r[8];
      run_instr(ir, z, cpi_of(ir, z), 1'b1, incs, wrs);
    end

    run_instr(8'hF0, 1'b0, 3, 1'b1, incs, wrs);
    for (int k = 0; k < 20; k++) begin
      o_t h;
      h = '0;
      h.hlt = 1'b1;
      bus.zero = 1'($urandom);
      #1;
      check($sformatf("halt_%0d", k), h);
      @(posedge clk);
      @(negedge clk);
    end

    rst_n = 1'b0;
    #1;
    check("halt_reset", '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);

    run_instr(8'h16, 1'b0, 4, 1'b0, incs, wrs);
    #1;
    rst_n = 1'b0;
    #1;
    check("reset_mid_ex1", '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_after_ex1", '0);
    @(posedge clk);
    @(negedge clk);
    run_instr(8'h00, 1'b0, 3, 1'b1, incs, wrs);
    run_instr(8'h2E, 1'b0, 4, 1'b1, incs, wrs);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
